// File: rtl/retire_unit_pkg.sv
// Shared configuration for the retire unit: architectural/physical register
// widths, the ROB entry layout (same field order rename uses to build
// entries) and the retire FSM state encoding.
package retire_unit_pkg;

  localparam int PROJ_LOG_ARCH      = 5;
  localparam int PROJ_LOG_PHYS      = 6;
  localparam int PROJ_NUM_ARCH_REGS = 32;
  localparam int ROB_ENTRY_BITS     = 110;

  // ROB entry, MSB -> LSB. Field offsets follow from this packing:
  //   done[109] instr[108:77] addr[76:45] alt_pc[44:13]
  //   req_alt_pc[12] has_dest[11] phys[10:5] arch[4:0]
  typedef struct packed {
    logic                     done;
    logic [31:0]              instr;
    logic [31:0]              addr;
    logic [31:0]              alt_pc;
    logic                     req_alt_pc;
    logic                     has_dest;
    logic [PROJ_LOG_PHYS-1:0] phys;
    logic [PROJ_LOG_ARCH-1:0] arch;
  } rob_entry_t;

  // Retire FSM: normal commit, or walking the R-RAT back into the F-RAT.
  typedef enum logic {
    RU_RUN     = 1'b0,
    RU_RECOVER = 1'b1
  } ru_state_e;

  // Reinterpret a raw ROB head bus as a structured entry.
  function automatic rob_entry_t to_rob_entry(input logic [ROB_ENTRY_BITS-1:0] bits);
    return rob_entry_t'(bits);
  endfunction

endpackage

// File: rtl/retire_unit_if.sv
// ROB head handshake between the reorder buffer (master) and the retire
// unit (slave).
// Handshake: ROB_head_valid says the head entry is meaningful; ROB_pop is a
// combinational accept, and the head is dequeued on the rising edge where
// ROB_head_valid and ROB_pop are both high. ROB_pop never depends on itself.
interface retire_unit_if;
  import retire_unit_pkg::*;

  logic [ROB_ENTRY_BITS-1:0] ROB_head_entry;
  logic                      ROB_head_valid;
  logic                      ROB_pop;

  modport master (
    output ROB_head_entry,
    output ROB_head_valid,
    input  ROB_pop
  );

  modport slave (
    input  ROB_head_entry,
    input  ROB_head_valid,
    output ROB_pop
  );

endinterface

// File: rtl/retire_unit_rrat.sv
// Retirement RAT: committed arch->phys mapping. One synchronous write port,
// two asynchronous read ports (commit lookup and recovery walk). Resets to
// the identity mapping.
module rrat_table
  import retire_unit_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [PROJ_LOG_ARCH-1:0] waddr_i,
  input  logic [PROJ_LOG_PHYS-1:0] wdata_i,
  input  logic [PROJ_LOG_ARCH-1:0] raddr_a_i,
  output logic [PROJ_LOG_PHYS-1:0] rdata_a_o,
  input  logic [PROJ_LOG_ARCH-1:0] raddr_b_i,
  output logic [PROJ_LOG_PHYS-1:0] rdata_b_o
);

  logic [PROJ_LOG_PHYS-1:0] mem_q [PROJ_NUM_ARCH_REGS];

  // Table storage: identity on reset, single committed write otherwise.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < PROJ_NUM_ARCH_REGS; i++) begin
        mem_q[i] <= PROJ_LOG_PHYS'(i);
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/retire_unit.sv
// Retire unit: commits one done ROB head per cycle, returns the displaced
// physical register to the free list, and on a mispredicted branch squashes
// the pipeline and walks the R-RAT into the F-RAT over 32 cycles.
module retire_unit
  import retire_unit_pkg::*;
(
  input  logic                     CLK,
  input  logic                     RESET,
  retire_unit_if.slave             rob,
  output logic                     Free_return_valid,
  output logic [PROJ_LOG_PHYS-1:0] Free_return_reg,
  output logic                     Frat_update,
  output logic [PROJ_LOG_ARCH-1:0] Frat_arch_reg,
  output logic [PROJ_LOG_PHYS-1:0] Frat_phy_reg,
  output logic                     Flush,
  output logic                     Redirect_valid,
  output logic [31:0]              Redirect_PC,
  output logic                     Recovering,
  output logic [31:0]              Retired_count,
  output ru_state_e                dbg_state_o
);

  rob_entry_t                head;
  ru_state_e                 state_q, state_d;
  logic [PROJ_LOG_ARCH-1:0]  index_q, index_d;
  logic                      pop;
  logic                      rrat_we;
  logic [PROJ_LOG_PHYS-1:0]  rrat_old;
  logic [PROJ_LOG_PHYS-1:0]  rrat_walk;

  logic                      free_valid_q, free_valid_d;
  logic [PROJ_LOG_PHYS-1:0]  free_reg_q, free_reg_d;
  logic                      redirect_q, redirect_d;
  logic [31:0]               redirect_pc_q, redirect_pc_d;
  logic [31:0]               count_q, count_d;

  logic                      unused_fields;

  assign head          = to_rob_entry(rob.ROB_head_entry);
  assign unused_fields = ^{head.instr, head.addr};

  // FSM state and walk index register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= RU_RUN;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  // Next state / pop: pop only in RUN, never while reset is held.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    pop     = 1'b0;
    case (state_q)
      RU_RUN: begin
        pop = RESET & rob.ROB_head_valid & head.done;
        if (pop && head.req_alt_pc) begin
          state_d = RU_RECOVER;
          index_d = '0;
        end
      end
      RU_RECOVER: begin
        index_d = index_q + 5'd1;
        if (index_q == PROJ_LOG_ARCH'(PROJ_NUM_ARCH_REGS - 1)) begin
          state_d = RU_RUN;
          index_d = '0;
        end
      end
      default: begin
        state_d = RU_RUN;
        index_d = '0;
      end
    endcase
  end

  assign rob.ROB_pop = pop;

  // Arch 0 is never remapped, so its phys goes straight back to the free list.
  assign rrat_we = pop & head.has_dest & (head.arch != '0);

  rrat_table u_rrat (
    .clk_i     (CLK),
    .rst_ni    (RESET),
    .we_i      (rrat_we),
    .waddr_i   (head.arch),
    .wdata_i   (head.phys),
    .raddr_a_i (head.arch),
    .rdata_a_o (rrat_old),
    .raddr_b_i (index_q),
    .rdata_b_o (rrat_walk)
  );

  // Commit-side next values for the registered outputs.
  always_comb begin
    free_valid_d  = pop & head.has_dest;
    free_reg_d    = free_reg_q;
    if (free_valid_d) begin
      free_reg_d = (head.arch != '0) ? rrat_old : head.phys;
    end
    redirect_d    = pop & head.req_alt_pc;
    redirect_pc_d = redirect_pc_q;
    if (redirect_d) begin
      redirect_pc_d = head.alt_pc;
    end
    count_d       = count_q + {31'd0, pop};
  end

  // Registered commit outputs: describe the entry popped last cycle.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      free_valid_q  <= 1'b0;
      free_reg_q    <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      count_q       <= '0;
    end else begin
      free_valid_q  <= free_valid_d;
      free_reg_q    <= free_reg_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      count_q       <= count_d;
    end
  end

  assign Free_return_valid = free_valid_q;
  assign Free_return_reg   = free_reg_q;
  assign Flush             = redirect_q;
  assign Redirect_valid    = redirect_q;
  assign Redirect_PC       = redirect_pc_q;
  assign Retired_count     = count_q;

  // Walk outputs follow the FSM directly; the F-RAT is only written here in RECOVER.
  assign Recovering    = (state_q == RU_RECOVER);
  assign Frat_update   = Recovering;
  assign Frat_arch_reg = Recovering ? index_q : '0;
  assign Frat_phy_reg  = Recovering ? rrat_walk : '0;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_retire_unit.sv
// Bench for retire_unit: drives ROB head entries, keeps a reference R-RAT and
// commit counter, and checks the registered commit outputs and the recovery walk.
module tb_retire_unit;
  import retire_unit_pkg::*;

  typedef struct packed {
    logic        fr_valid;
    logic [5:0]  fr_reg;
    logic [31:0] count;
    logic        redirect;
    logic [31:0] pc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Free_return_valid;
  logic [5:0]  Free_return_reg;
  logic        Frat_update;
  logic [4:0]  Frat_arch_reg;
  logic [5:0]  Frat_phy_reg;
  logic        Flush;
  logic        Redirect_valid;
  logic [31:0] Redirect_PC;
  logic        Recovering;
  logic [31:0] Retired_count;
  ru_state_e   dbg_state;

  exp_t        exp_q[$];
  logic [5:0]  model_rrat [32];
  logic [31:0] model_count;
  int          checks = 0;
  int          errors = 0;

  retire_unit_if rob_if ();

  retire_unit dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .rob               (rob_if),
    .Free_return_valid (Free_return_valid),
    .Free_return_reg   (Free_return_reg),
    .Frat_update       (Frat_update),
    .Frat_arch_reg     (Frat_arch_reg),
    .Frat_phy_reg      (Frat_phy_reg),
    .Flush             (Flush),
    .Redirect_valid    (Redirect_valid),
    .Redirect_PC       (Redirect_PC),
    .Recovering        (Recovering),
    .Retired_count     (Retired_count),
    .dbg_state_o       (dbg_state)
  );

  // Clock and watchdog.
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic rob_entry_t mk(input logic done, input logic has_dest,
                                    input logic [4:0] arch, input logic [5:0] phys,
                                    input logic req_alt, input logic [31:0] alt_pc);
    rob_entry_t e;
    e.done       = done;
    e.instr      = $urandom;
    e.addr       = $urandom;
    e.alt_pc     = alt_pc;
    e.req_alt_pc = req_alt;
    e.has_dest   = has_dest;
    e.phys       = phys;
    e.arch       = arch;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_rrat[i] = 6'(i);
    model_count = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    rob_if.ROB_head_valid = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    model_reset();
  endtask

  // Driver + scoreboard step: present one head for one cycle (starting and
  // ending at a falling edge), predict the pop, then compare the outputs.
  task automatic cycle_commit(input rob_entry_t e, input logic v, input string tag);
    logic exp_pop;
    exp_t x;
    rob_if.ROB_head_entry = e;
    rob_if.ROB_head_valid = v;
    exp_pop = v & e.done;
    #1;
    checks++;
    if (rob_if.ROB_pop !== exp_pop) begin
      errors++;
      $display("FAIL %s rob_pop: got %b expected %b", tag, rob_if.ROB_pop, exp_pop);
    end
    if (exp_pop) begin
      x.fr_valid = e.has_dest;
      x.fr_reg   = (e.arch != 5'd0) ? model_rrat[e.arch] : e.phys;
      if (e.has_dest && e.arch != 5'd0) model_rrat[e.arch] = e.phys;
      model_count = model_count + 1;
      x.count    = model_count;
      x.redirect = e.req_alt_pc;
      x.pc       = e.alt_pc;
      exp_q.push_back(x);
    end
    @(negedge CLK);
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
    end else begin
      x = '0;
      x.count = model_count;
    end
    checks++;
    if (Free_return_valid !== x.fr_valid) begin
      errors++;
      $display("FAIL %s free_valid: got %b expected %b", tag, Free_return_valid, x.fr_valid);
    end
    if (x.fr_valid) begin
      checks++;
      if (Free_return_reg !== x.fr_reg) begin
        errors++;
        $display("FAIL %s free_reg: got %0d expected %0d", tag, Free_return_reg, x.fr_reg);
      end
    end
    checks++;
    if (Retired_count !== x.count) begin
      errors++;
      $display("FAIL %s retired_count: got %0d expected %0d", tag, Retired_count, x.count);
    end
    checks++;
    if (Flush !== x.redirect || Redirect_valid !== x.redirect || Frat_update !== x.redirect) begin
      errors++;
      $display("FAIL %s flush/redirect/frat: got %b/%b/%b expected %b", tag,
               Flush, Redirect_valid, Frat_update, x.redirect);
    end
    if (x.redirect) begin
      checks++;
      if (Redirect_PC !== x.pc) begin
        errors++;
        $display("FAIL %s redirect_pc: got %h expected %h", tag, Redirect_PC, x.pc);
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    rob_if.ROB_head_entry = mk(1'b1, 1'b1, 5'd3, 6'd40, 1'b1, 32'hdead_beef);
    rob_if.ROB_head_valid = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (rob_if.ROB_pop !== 1'b0) begin
      errors++;
      $display("FAIL reset rob_pop: got %b expected 0", rob_if.ROB_pop);
    end
    checks++;
    if ({Free_return_valid, Flush, Redirect_valid, Frat_update, Recovering} !== 5'b0) begin
      errors++;
      $display("FAIL reset pulses: got %b expected 00000",
               {Free_return_valid, Flush, Redirect_valid, Frat_update, Recovering});
    end
    checks++;
    if (Redirect_PC !== 32'd0 || Free_return_reg !== 6'd0 || Frat_arch_reg !== 5'd0 ||
        Frat_phy_reg !== 6'd0) begin
      errors++;
      $display("FAIL reset regs: got pc=%h fr=%0d fa=%0d fp=%0d expected all 0",
               Redirect_PC, Free_return_reg, Frat_arch_reg, Frat_phy_reg);
    end
    checks++;
    if (Retired_count !== 32'd0 || dbg_state !== RU_RUN) begin
      errors++;
      $display("FAIL reset count/state: got %0d/%0d expected 0/0", Retired_count, dbg_state);
    end
    @(negedge CLK);
    RESET = 1'b1;
    rob_if.ROB_head_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    cycle_commit(mk(1'b1, 1'b1, 5'd3, 6'd40, 1'b0, 32'd0), 1'b1, "single");
    checks++;
    if (Free_return_reg !== 6'd3 || Retired_count !== 32'd1) begin
      errors++;
      $display("FAIL single values: got fr=%0d cnt=%0d expected 3/1", Free_return_reg, Retired_count);
    end
    checks++;
    if (dut.u_rrat.mem_q[3] !== 6'd40) begin
      errors++;
      $display("FAIL single rrat3: got %0d expected 40", dut.u_rrat.mem_q[3]);
    end
    cycle_commit(mk(1'b1, 1'b1, 5'd3, 6'd41, 1'b0, 32'd0), 1'b0, "single_idle");
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycle_commit(mk(1'b1, 1'b1, 5'd3, 6'd40, 1'b0, 32'd0), 1'b1, "b2b_first");
    checks++;
    if (Free_return_reg !== 6'd3) begin
      errors++;
      $display("FAIL b2b_first reg: got %0d expected 3", Free_return_reg);
    end
    cycle_commit(mk(1'b1, 1'b1, 5'd3, 6'd41, 1'b0, 32'd0), 1'b1, "b2b_second");
    checks++;
    if (Free_return_reg !== 6'd40 || Free_return_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second reg: got %0d/%b expected 40/1", Free_return_reg, Free_return_valid);
    end
    checks++;
    if (dut.u_rrat.mem_q[3] !== 6'd41) begin
      errors++;
      $display("FAIL b2b rrat3: got %0d expected 41", dut.u_rrat.mem_q[3]);
    end
  endtask

  task automatic test_arch_zero();
    cycle_commit(mk(1'b1, 1'b1, 5'd0, 6'd50, 1'b0, 32'd0), 1'b1, "arch0");
    checks++;
    if (Free_return_reg !== 6'd50) begin
      errors++;
      $display("FAIL arch0 reg: got %0d expected 50", Free_return_reg);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.u_rrat.mem_q[i] !== model_rrat[i]) begin
        errors++;
        $display("FAIL arch0 rrat[%0d]: got %0d expected %0d", i, dut.u_rrat.mem_q[i], model_rrat[i]);
      end
    end
  endtask

  task automatic test_no_dest();
    cycle_commit(mk(1'b1, 1'b0, 5'd7, 6'd9, 1'b0, 32'd0), 1'b1, "no_dest");
    checks++;
    if (dut.u_rrat.mem_q[7] !== 6'd7) begin
      errors++;
      $display("FAIL no_dest rrat7: got %0d expected 7", dut.u_rrat.mem_q[7]);
    end
  endtask

  task automatic test_not_done();
    for (int i = 0; i < 5; i++) begin
      cycle_commit(mk(1'b0, 1'b1, 5'd5, 6'd20, 1'b1, 32'h1000), 1'b1, "not_done");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      cycle_commit(mk(1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(31)),
                      6'($urandom_range(63)), 1'b0, 32'd0),
                   1'($urandom_range(3) != 0), "random");
    end
  endtask

  task automatic test_branch();
    do_reset();
    cycle_commit(mk(1'b1, 1'b1, 5'd3, 6'd40, 1'b0, 32'd0), 1'b1, "br_setup");
    cycle_commit(mk(1'b1, 1'b0, 5'd0, 6'd0, 1'b1, 32'h0040_0100), 1'b1, "branch");
    checks++;
    if (Flush !== 1'b1 || Redirect_PC !== 32'h0040_0100) begin
      errors++;
      $display("FAIL branch redirect: got flush=%b pc=%h expected 1/00400100", Flush, Redirect_PC);
    end
    rob_if.ROB_head_entry = mk(1'b1, 1'b1, 5'd5, 6'd33, 1'b0, 32'd0);
    rob_if.ROB_head_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      checks++;
      if (rob_if.ROB_pop !== 1'b0 || Recovering !== 1'b1 || Frat_update !== 1'b1) begin
        errors++;
        $display("FAIL walk[%0d] ctrl: got pop=%b rec=%b upd=%b expected 0/1/1",
                 i, rob_if.ROB_pop, Recovering, Frat_update);
      end
      checks++;
      if (Frat_arch_reg !== 5'(i) || Frat_phy_reg !== model_rrat[i]) begin
        errors++;
        $display("FAIL walk[%0d] write: got (%0d,%0d) expected (%0d,%0d)",
                 i, Frat_arch_reg, Frat_phy_reg, i, model_rrat[i]);
      end
      if (i == 3) begin
        checks++;
        if (Frat_phy_reg !== 6'd40) begin
          errors++;
          $display("FAIL walk[3] phys: got %0d expected 40", Frat_phy_reg);
        end
      end
      if (i >= 1) begin
        checks++;
        if (Flush !== 1'b0 || Redirect_valid !== 1'b0) begin
          errors++;
          $display("FAIL walk[%0d] pulse: got flush=%b redir=%b expected 0/0", i, Flush, Redirect_valid);
        end
      end
      if (i == 31) rob_if.ROB_head_valid = 1'b0;
      @(negedge CLK);
    end
    #1;
    checks++;
    if (Recovering !== 1'b0 || Frat_update !== 1'b0 || dbg_state !== RU_RUN ||
        Retired_count !== model_count) begin
      errors++;
      $display("FAIL walk_end: got rec=%b upd=%b state=%0d cnt=%0d expected 0/0/0/%0d",
               Recovering, Frat_update, dbg_state, Retired_count, model_count);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_recover();
    do_reset();
    cycle_commit(mk(1'b1, 1'b1, 5'd4, 6'd44, 1'b1, 32'h0000_1234), 1'b1, "mid_branch");
    rob_if.ROB_head_entry = mk(1'b1, 1'b1, 5'd6, 6'd30, 1'b0, 32'd0);
    rob_if.ROB_head_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 10) begin
        #1;
        checks++;
        if (Frat_arch_reg !== 5'd10 || Recovering !== 1'b1) begin
          errors++;
          $display("FAIL mid index: got %0d/%b expected 10/1", Frat_arch_reg, Recovering);
        end
        RESET = 1'b0;
      end
      @(negedge CLK);
    end
    #1;
    checks++;
    if (rob_if.ROB_pop !== 1'b0 || Recovering !== 1'b0 || Frat_update !== 1'b0 ||
        dbg_state !== RU_RUN || Retired_count !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: got pop=%b rec=%b upd=%b state=%0d cnt=%0d expected 0/0/0/0/0",
               rob_if.ROB_pop, Recovering, Frat_update, dbg_state, Retired_count);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.u_rrat.mem_q[i] !== 6'(i)) begin
        errors++;
        $display("FAIL mid_reset rrat[%0d]: got %0d expected %0d", i, dut.u_rrat.mem_q[i], i);
      end
    end
    @(negedge CLK);
    RESET = 1'b1;
    rob_if.ROB_head_valid = 1'b0;
    model_reset();
    @(negedge CLK);
  endtask

  // Test sequence and final report.
  initial begin
    rob_if.ROB_head_entry = '0;
    rob_if.ROB_head_valid = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_arch_zero();
    test_no_dest();
    test_not_done();
    test_random();
    test_branch();
    test_reset_mid_recover();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
